// File: rtl/sumador_rizado_ctrl.sv
// Launch/capture control around an external ripple-carry adder (SUM_RIZADO).
// Operands are accepted on a valid/ready handshake and launched to the adder
// from flops. After a fixed settle time the sum and carry are captured and
// offered downstream. Toggles of the launched operand bits are accumulated in
// a saturating counter.
// Ports:
//   clk, reset_L               clock, async active-low reset
//   in_valid/in_ready          operand handshake (in_ready decoded from state)
//   in_a, in_b, in_ci          operands and carry in
//   add_a, add_b, add_ci       registered operands driven to the adder
//   add_s, add_co              adder result (combinational from the adder)
//   out_valid/out_ready        result handshake
//   out_s, out_co              captured sum and carry out
//   tog_clr, tog_cnt           toggle counter clear and value
module sumador_rizado_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co,
  input  logic             tog_clr,
  output logic [CNT_W-1:0] tog_cnt
);

  localparam int unsigned VEC_W   = 2 * WIDTH + 1;
  localparam int unsigned DELTA_W = $clog2(VEC_W + 1);
  localparam int unsigned SUM_W   = ((CNT_W > DELTA_W) ? CNT_W : DELTA_W) + 1;
  localparam int unsigned SCNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [SCNT_W-1:0]   scnt, scnt_n;
  logic [WIDTH-1:0]    add_a_n, add_b_n, out_s_n;
  logic                add_ci_n, out_co_n, out_valid_n;
  logic [CNT_W-1:0]    tog_n, tog_base, tog_sat;
  logic [DELTA_W-1:0]  delta;
  logic [SUM_W-1:0]    tog_sum;

  // Number of set bits in a launch-vector difference.
  function automatic logic [DELTA_W-1:0] popcount(input logic [VEC_W-1:0] v);
    logic [DELTA_W-1:0] n;
    n = '0;
    for (int i = 0; i < VEC_W; i++) begin
      n = n + DELTA_W'(v[i]);
    end
    return n;
  endfunction

  assign in_ready = (state == ST_IDLE);

  // Bits that would switch on the adder inputs if the offered beat is launched.
  assign delta = popcount({in_a, in_b, in_ci} ^ {add_a, add_b, add_ci});

  // Clear takes effect first so a simultaneous accept lands on a zero base.
  assign tog_base = tog_clr ? '0 : tog_cnt;
  assign tog_sum  = SUM_W'(tog_base) + SUM_W'(delta);
  assign tog_sat  = (tog_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                      : tog_sum[CNT_W-1:0];

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= ST_IDLE;
      scnt      <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_ci    <= 1'b0;
      out_s     <= '0;
      out_co    <= 1'b0;
      out_valid <= 1'b0;
      tog_cnt   <= '0;
    end else begin
      state     <= state_n;
      scnt      <= scnt_n;
      add_a     <= add_a_n;
      add_b     <= add_b_n;
      add_ci    <= add_ci_n;
      out_s     <= out_s_n;
      out_co    <= out_co_n;
      out_valid <= out_valid_n;
      tog_cnt   <= tog_n;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n     = state;
    scnt_n      = scnt;
    add_a_n     = add_a;
    add_b_n     = add_b;
    add_ci_n    = add_ci;
    out_s_n     = out_s;
    out_co_n    = out_co;
    out_valid_n = out_valid;
    tog_n       = tog_base;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          add_a_n  = in_a;
          add_b_n  = in_b;
          add_ci_n = in_ci;
          scnt_n   = SCNT_W'(SETTLE - 1);
          tog_n    = tog_sat;
          state_n  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (scnt != '0) begin
          scnt_n = scnt - SCNT_W'(1);
        end else begin
          out_s_n     = add_s;
          out_co_n    = add_co;
          out_valid_n = 1'b1;
          state_n     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end
      end
      default: begin
        out_valid_n = 1'b0;
        state_n     = ST_IDLE;
      end
    endcase
  end

endmodule
